alu_op_issuer: RTL and testbench
================================

Name: alu_op_issuer

Overview:
- Issue-side controller for the 32-bit ALU block.
- Accepts an R-type funct code plus operands through a valid/ready handshake and drives the ALU `Signal`/operand bus.
- Registers the ALU result and returns it through a valid/ready response handshake.
- Adds multi-cycle MULTU with HI/LO registers and MFHI/MFLO readback; sits between the decode stage and the ALU in the midterm datapath.

Parameters:
- DATA_W, 32, operand/result width; must equal ALU width.
- MUL_STEPS, 32, shift-add iterations for MULTU; must equal DATA_W.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  issuer can accept a request.
- funct  input  6  operation code.
- op_a  input  DATA_W  operand A.
- op_b  input  DATA_W  operand B.
- alu_signal  output  6  function code to ALU.
- alu_a  output  DATA_W  ALU operand A.
- alu_b  output  DATA_W  ALU operand B.
- alu_result  input  DATA_W  combinational ALU output.
- out_valid  output  1  response valid.
- out_ready  input  1  consumer accepts response.
- out_data  output  DATA_W  result.
- out_err  output  1  unsupported funct.
- busy  output  1  high in MUL state.

Behaviour:
- Function codes:
  - AND = 36, OR = 37, ADD = 32, SUB = 34, SLT = 42: single-cycle ALU ops.
  - MULTU = 25, MFHI = 16, MFLO = 18.
  - Any other code is illegal.
- Reset (reset = 0, asynchronous):
  - State goes to IDLE.
  - in_ready = 1; out_valid = 0; out_data = 0; out_err = 0; busy = 0.
  - alu_signal = 0; alu_a = 0; alu_b = 0; HI = 0; LO = 0.
  - A reset mid-operation aborts the multiply and discards any pending response.
- State IDLE:
  - in_ready = 1. A transfer occurs when in_valid && in_ready.
  - On an ALU op: latch funct/op_a/op_b into alu_signal/alu_a/alu_b and go to EXEC.
  - On MULTU: latch multiplicand = op_a, LO = op_b, HI = 0, count = 0; go to MUL.
  - On MFHI/MFLO: load out_data = HI/LO and go to RESP.
  - On an illegal code: out_data = 0, out_err = 1, go to RESP.
- State EXEC:
  - Lasts one cycle; in_ready = 0.
  - Capture out_data = alu_result and go to RESP.
  - ALU-op latency is 2 cycles from the accept edge to out_valid.
- State MUL:
  - busy = 1; in_ready = 0.
  - Each cycle, use an internal 33-bit sum s = {1'b0, HI} + (LO[0] ? multiplicand : 0).
  - Update {HI, LO} = {s, LO[DATA_W-1:1]}; count++.
  - After MUL_STEPS iterations (count == MUL_STEPS-1 on the update edge), go to RESP with out_data = 0.
  - The MULTU response indicates completion only; the result is read via MFHI/MFLO.
- State RESP:
  - out_valid = 1; out_data/out_err held stable until out_valid && out_ready.
  - On handshake: clear out_valid and out_err, return to IDLE.
  - in_ready = 0 while in RESP, so there is no overlap or back-to-back issue.
  - Minimum request spacing: 3 cycles for ALU ops, 2 for MFHI/MFLO/illegal.
- alu_signal/alu_a/alu_b hold their last values outside EXEC, so the ALU sees stable inputs.
- HI/LO change only during MUL and are preserved across ALU ops and illegal codes.
- Arithmetic is modulo 2^DATA_W for ALU ops, exactly as the ALU computes it.
- MULTU is unsigned and full 64-bit exact.
- in_valid while busy is ignored; the requester must hold the request until in_ready.

Optional Feature:
- Macro: ALU_ISSUER_SIGNED_MULT_EN.
- Defined: funct 24 (MULT, signed) is supported.
  - On accept, latch |op_a| and |op_b| and a sign flag = op_a[31] ^ op_b[31].
  - Run the same MUL sequence.
  - One extra FIX cycle before RESP negates {HI, LO} as 64-bit two's complement if the sign flag is set.
- Undefined: funct 24 is illegal (out_err = 1); no FIX state or sign logic is present.

Test Plan:
- Reset, then issue ADD 5 + 7 with an ALU model attached → alu_signal = 32 in EXEC; out_valid 2 cycles after accept with out_data = 12, out_err = 0.
- SUB 3 - 5 then SLT 3, 5 → out_data = 0xFFFFFFFE, then 1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → busy high 32 cycles; completion response; then MFHI = 0xFFFFFFFE and MFLO = 0x00000001.
- Illegal funct 0x3F → out_err = 1, out_data = 0; HI/LO unchanged.
- Hold out_ready = 0 for 5 cycles during RESP → out_valid/out_data stable and in_ready = 0 throughout; then release and check the handshake completes and in_ready returns to 1.
- Assert reset at MUL count 10 → all outputs return to reset values immediately; MFLO then returns 0.
- With the macro defined: MULT −3 × 4 gives HI = 0xFFFFFFFF, LO = 0xFFFFFFF4. With it undefined, funct 24 gives out_err = 1.

Source files
------------

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: issue-side controller for the 32-bit ALU.
// Accepts funct/operands over valid/ready, drives the ALU bus, returns the
// registered result over a valid/ready response. Adds a multi-cycle
// shift-add MULTU into HI/LO with MFHI/MFLO readback.
// Optional feature macro: ALU_ISSUER_SIGNED_MULT_EN adds signed MULT (funct 24)
// through magnitude multiply plus a final FIX negation cycle.
module alu_op_issuer #(
  parameter int DATA_W    = 32,
  parameter int MUL_STEPS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [5:0]        alu_signal,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(MUL_STEPS);

  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
`ifdef ALU_ISSUER_SIGNED_MULT_EN
  localparam logic [5:0] F_MULT  = 6'd24;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
`ifdef ALU_ISSUER_SIGNED_MULT_EN
    S_FIX,
`endif
    S_RESP
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] mcand;
  logic [CNT_W-1:0]  count;
  logic [DATA_W:0]   mul_sum;
`ifdef ALU_ISSUER_SIGNED_MULT_EN
  logic              sign_flag;
  logic              is_signed;

  // Magnitude of a two's complement operand; the most negative value maps to
  // its unsigned magnitude, which the unsigned multiplier handles exactly.
  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
  endfunction

  // 64-bit two's complement negation of the {HI, LO} product.
  function automatic logic [2*DATA_W-1:0] neg2(input logic [2*DATA_W-1:0] v);
    return ~v + (2*DATA_W)'(1);
  endfunction
`endif

  // Shift-add partial sum: add the multiplicand into HI when the LO bit shifted out is set.
  always_comb begin
    mul_sum = {1'b0, hi} + {1'b0, (lo[0] ? mcand : {DATA_W{1'b0}})};
  end

  // Issuer FSM with registered handshake, ALU bus and HI/LO state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_err    <= 1'b0;
      busy       <= 1'b0;
      alu_signal <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      hi         <= '0;
      lo         <= '0;
      mcand      <= '0;
      count      <= '0;
`ifdef ALU_ISSUER_SIGNED_MULT_EN
      sign_flag  <= 1'b0;
      is_signed  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            case (funct)
              F_ADD, F_SUB, F_AND, F_OR, F_SLT: begin
                alu_signal <= funct;
                alu_a      <= op_a;
                alu_b      <= op_b;
                state      <= S_EXEC;
              end
              F_MULTU: begin
                mcand     <= op_a;
                lo        <= op_b;
                hi        <= '0;
                count     <= '0;
                busy      <= 1'b1;
`ifdef ALU_ISSUER_SIGNED_MULT_EN
                is_signed <= 1'b0;
                sign_flag <= 1'b0;
`endif
                state     <= S_MUL;
              end
`ifdef ALU_ISSUER_SIGNED_MULT_EN
              F_MULT: begin
                mcand     <= abs_val(op_a);
                lo        <= abs_val(op_b);
                hi        <= '0;
                count     <= '0;
                busy      <= 1'b1;
                is_signed <= 1'b1;
                sign_flag <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
                state     <= S_MUL;
              end
`endif
              F_MFHI: begin
                out_data  <= hi;
                out_valid <= 1'b1;
                state     <= S_RESP;
              end
              F_MFLO: begin
                out_data  <= lo;
                out_valid <= 1'b1;
                state     <= S_RESP;
              end
              default: begin
                out_data  <= '0;
                out_err   <= 1'b1;
                out_valid <= 1'b1;
                state     <= S_RESP;
              end
            endcase
          end
        end
        S_EXEC: begin
          out_data  <= alu_result;
          out_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_MUL: begin
          hi    <= mul_sum[DATA_W:1];
          lo    <= {mul_sum[0], lo[DATA_W-1:1]};
          count <= count + CNT_W'(1);
          if (count == CNT_W'(MUL_STEPS - 1)) begin
            busy     <= 1'b0;
            out_data <= '0;
`ifdef ALU_ISSUER_SIGNED_MULT_EN
            if (is_signed) begin
              state <= S_FIX;
            end else begin
              out_valid <= 1'b1;
              state     <= S_RESP;
            end
`else
            out_valid <= 1'b1;
            state     <= S_RESP;
`endif
          end
        end
`ifdef ALU_ISSUER_SIGNED_MULT_EN
        S_FIX: begin
          if (sign_flag) begin
            {hi, lo} <= neg2({hi, lo});
          end
          out_valid <= 1'b1;
          state     <= S_RESP;
        end
`endif
        S_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Testbench for alu_op_issuer: behavioural ALU attached to the ALU bus,
// table of single-transaction vectors plus hand-written multi-cycle sequences.
module tb_alu_op_issuer;

  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        funct;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [5:0]        alu_signal;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;
  logic              busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        e;
  } vec_t;

  vec_t        tbl[13];
  logic [32:0] sb[$];

  alu_op_issuer #(.DATA_W(DATA_W), .MUL_STEPS(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .op_a(op_a), .op_b(op_b), .alu_signal(alu_signal),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 32-bit ALU
  always_comb begin
    alu_result = '0;
    case (alu_signal)
      6'd32: alu_result = alu_a + alu_b;
      6'd34: alu_result = alu_a - alu_b;
      6'd36: alu_result = alu_a & alu_b;
      6'd37: alu_result = alu_a | alu_b;
      6'd42: alu_result = {31'b0, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Drive a request, wait (bounded) for acceptance, push the expected response.
  task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ed, input logic ee);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; funct = f; op_a = a; op_b = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: got in_ready=0, required 1 (funct %0d)", f);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      sb.push_back({ee, ed});
      #1 in_valid = 1'b0;
    end
  endtask

  // Wait (bounded) for a response, compare against the scoreboard, complete handshake.
  task automatic recv(input string name);
    int n = 0;
    logic [32:0] exp;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: got out_valid=0, required 1", name);
    end else if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s_unexpected: got response %h, required none", name, out_data);
    end else begin
      exp = sb.pop_front();
      chk({name, "_data"}, out_data, exp[31:0]);
      chk({name, "_err"}, {31'b0, out_err}, {31'b0, exp[32]});
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int nb;
    tbl[0]  = '{6'd34, 32'd3,          32'd5,          32'hFFFF_FFFE, 1'b0};
    tbl[1]  = '{6'd42, 32'd3,          32'd5,          32'd1,         1'b0};
    tbl[2]  = '{6'd42, 32'd5,          32'd3,          32'd0,         1'b0};
    tbl[3]  = '{6'd42, 32'hFFFF_FFFF,  32'd1,          32'd1,         1'b0};
    tbl[4]  = '{6'd36, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000, 1'b0};
    tbl[5]  = '{6'd37, 32'h0000_F0F0,  32'h0000_0F0F,  32'h0000_FFFF, 1'b0};
    tbl[6]  = '{6'd32, 32'hFFFF_FFFF,  32'd1,          32'd0,         1'b0};
    tbl[7]  = '{6'h3F, 32'd1,          32'd2,          32'd0,         1'b1};
    tbl[8]  = '{6'd16, 32'd0,          32'd0,          32'hFFFF_FFFE, 1'b0};
    tbl[9]  = '{6'd18, 32'd0,          32'd0,          32'h0000_0001, 1'b0};
`ifdef ALU_ISSUER_SIGNED_MULT_EN
    tbl[10] = '{6'd24, 32'hFFFF_FFFD,  32'd4,          32'd0,         1'b0};
    tbl[11] = '{6'd16, 32'd0,          32'd0,          32'hFFFF_FFFF, 1'b0};
    tbl[12] = '{6'd18, 32'd0,          32'd0,          32'hFFFF_FFF4, 1'b0};
`else
    tbl[10] = '{6'd24, 32'hFFFF_FFFD,  32'd4,          32'd0,         1'b1};
    tbl[11] = '{6'd16, 32'd0,          32'd0,          32'hFFFF_FFFE, 1'b0};
    tbl[12] = '{6'd18, 32'd0,          32'd0,          32'h0000_0001, 1'b0};
`endif

    reset = 1'b0; in_valid = 1'b0; funct = '0; op_a = '0; op_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",   {31'b0, in_ready},   32'd1);
    chk("rst_out_valid",  {31'b0, out_valid},  32'd0);
    chk("rst_busy",       {31'b0, busy},       32'd0);
    chk("rst_out_err",    {31'b0, out_err},    32'd0);
    chk("rst_out_data",   out_data,            32'd0);
    chk("rst_alu_signal", {26'b0, alu_signal}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // ADD 5 + 7: EXEC bus contents and 2-cycle latency
    send(6'd32, 32'd5, 32'd7, 32'd12, 1'b0);
    @(negedge clk);
    chk("exec_alu_signal", {26'b0, alu_signal}, 32'd32);
    chk("exec_alu_a",      alu_a,               32'd5);
    chk("exec_alu_b",      alu_b,               32'd7);
    chk("exec_out_valid",  {31'b0, out_valid},  32'd0);
    chk("exec_in_ready",   {31'b0, in_ready},   32'd0);
    @(posedge clk);
    #1;
    chk("add_latency_valid", {31'b0, out_valid}, 32'd1);
    recv("add");

    // MULTU 0xFFFFFFFF x 0xFFFFFFFF: busy for 32 cycles, then completion
    send(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0);
    nb = 0;
    for (int i = 0; i < 200 && !out_valid; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk("multu_busy_cycles", nb, 32'd32);
    chk("multu_busy_end", {31'b0, busy}, 32'd0);
    recv("multu");

    // Table of single-transaction vectors
    for (int i = 0; i < 13; i++) begin
      send(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].e);
      recv($sformatf("vec%0d", i));
    end

    // Response backpressure: 5 stalled cycles then release
    out_ready = 1'b0;
    send(6'd32, 32'd1, 32'd1, 32'd2, 1'b0);
    for (int i = 0; i < 200 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_out_data",  out_data,           32'd2);
      chk("stall_in_ready",  {31'b0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    recv("stall");
    chk("release_out_valid", {31'b0, out_valid}, 32'd0);
    chk("release_in_ready",  {31'b0, in_ready},  32'd1);

    // Reset in the middle of a multiply at count 10
    send(6'd25, 32'd5, 32'd7, 32'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("pre_abort_busy", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    sb.delete();
    chk("abort_in_ready",  {31'b0, in_ready},  32'd1);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_busy",      {31'b0, busy},      32'd0);
    chk("abort_out_data",  out_data,           32'd0);
    chk("abort_alu_a",     alu_a,              32'd0);
    @(negedge clk);
    reset = 1'b1;
    send(6'd18, 32'd0, 32'd0, 32'd0, 1'b0);
    recv("abort_mflo");
    send(6'd16, 32'd0, 32'd0, 32'd0, 1'b0);
    recv("abort_mfhi");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
